custom_axi_ip_mc: RTL and testbench
===================================

CUSTOM_AXI_IP_MC -- requirements
Module: custom_axi_ip_mc

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter NUM_CH, default 4, number of requesting channels (2..16).
REQ-003 SHALL have parameter CNT_W, default 4, width of per-channel iteration count.
REQ-004 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port ipreg_data_i  input  NUM_CH*DATA_WIDTH  per-channel operand; channel c at [c*DATA_WIDTH +: DATA_WIDTH].
REQ-007 SHALL have port ipreg_iter_i  input  NUM_CH*CNT_W  per-channel increment count; channel c at [c*CNT_W +: CNT_W].
REQ-008 SHALL have port enable_i  input  NUM_CH  per-channel request level.
REQ-009 SHALL have port clear_i  input  1  error-clear pulse.
REQ-010 SHALL have port ipreg_data_o  output  DATA_WIDTH  result of last completed operation.
REQ-011 SHALL have port wen_o  output  NUM_CH  one-hot, one-cycle write-enable to the served channel's register.
REQ-012 SHALL have port ch_o  output  $clog2(NUM_CH)  index of channel currently or last served.
REQ-013 SHALL have port status_o  output  status_e  current FSM state.
REQ-014 SHALL have port err_o  output  1  high while in ERROR.

Function
REQ-015 SHALL implement FSM states IDLE, BUSY, DONE, ERROR; status_o SHALL equal the registered state.
REQ-016 IDLE: if any enable_i bit set, SHALL grant one channel round-robin, starting after last-granted index; latch its operand, count and index into ch_o; next state BUSY.
REQ-017 IDLE: if granted channel's count is 0, SHALL latch index, go to ERROR instead of BUSY, no write-back.
REQ-018 BUSY: each cycle internal value += 1 and count -= 1; when count reaches 0, next state DONE; BUSY therefore lasts exactly iter cycles.
REQ-019 DONE: ipreg_data_o SHALL load the result and wen_o[ch] SHALL pulse high for exactly one cycle (registered, same cycle as new ipreg_data_o); next state IDLE.
REQ-020 Latency from grant edge to wen_o: iter+1 cycles; new grant no earlier than the cycle after DONE.
REQ-021 Arithmetic: result = operand + iter, DATA_WIDTH bits, modulo 2^DATA_WIDTH unless REQ-029 applies.
REQ-022 Request is level-based: requester SHALL hold enable_i until its wen_o; a bit still high in the IDLE after DONE is a new request; drops during BUSY do not abort.
REQ-023 ipreg_data_i/ipreg_iter_i changes after grant SHALL NOT affect the running operation.
REQ-024 ERROR: err_o=1, wen_o=0, all requests ignored; clear_i=1 SHALL return to IDLE next cycle; clear_i outside ERROR ignored.
REQ-025 Unreachable state encodings SHALL transition to ERROR.
REQ-026 No simulation-only display statements in synthesised logic.

Reset
REQ-027 On rst_ni low, immediately: state IDLE, ipreg_data_o=0, wen_o=0, ch_o=0, err_o=0, internal value/count=0, round-robin pointer=NUM_CH-1 (channel 0 first); reset mid-BUSY SHALL discard the operation with no wen_o.
REQ-028 All state elements, including internal data, SHALL be in the async-reset process.

Configuration
REQ-029 Macro CUSTOM_AXI_IP_MC_SAT_EN defined: increments SHALL saturate at all-ones (BUSY duration unchanged); undefined: modulo wrap per REQ-021.

Structure
REQ-030 status_e (2-bit: IDLE=0, BUSY=1, DONE=2, ERROR=3) SHALL live in custom_axi_ip_pkg.
REQ-031 Round-robin arbiter SHALL be sub-module custom_axi_ip_rr_arb (NUM_CH req in, one-hot grant and index out, pointer updated on accept).

Verification
REQ-032 Single op: ch0 data=0x10, iter=3, enable_i=0001 -> wen_o=0001 exactly 4 cycles after grant, ipreg_data_o=0x13, ch_o=0.
REQ-033 Round-robin: enable_i=1111 held, iter=1 all -> serve order 0,1,2,3,0; each wen_o one-hot, one cycle.
REQ-034 Wrap: data=0xFFFFFFFE, iter=3 -> 0x00000001; with CUSTOM_AXI_IP_MC_SAT_EN -> 0xFFFFFFFF.
REQ-035 Error: ch2 iter=0 -> ERROR, err_o=1, status_o=3, no wen_o; clear_i pulse -> IDLE next cycle, err_o=0.
REQ-036 Reset mid-BUSY: ch1 iter=8, rst_ni low at BUSY cycle 4 -> all outputs 0, IDLE, no wen_o; after release, enable_i=0011 grants ch0 first.

Source files
------------

// File: rtl/custom_axi_ip_pkg.sv
// Shared types and constants for the custom_axi_ip_mc multi-channel incrementer.
// Contents: status_e (externally visible FSM status) and the FSM state encodings.
package custom_axi_ip_pkg;

  // Externally visible FSM status; values match the state encodings below.
  typedef enum logic [1:0] {
    STATUS_IDLE  = 2'd0,
    STATUS_BUSY  = 2'd1,
    STATUS_DONE  = 2'd2,
    STATUS_ERROR = 2'd3
  } status_e;

  localparam int unsigned STATE_W = 2;

  // FSM state encodings
  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ST_BUSY  = 2'd1;
  localparam logic [STATE_W-1:0] ST_DONE  = 2'd2;
  localparam logic [STATE_W-1:0] ST_ERROR = 2'd3;

  // Map a raw state encoding onto the status enum.
  function automatic status_e to_status(input logic [STATE_W-1:0] st);
    return status_e'(st);
  endfunction

endpackage

// File: rtl/custom_axi_ip_mc_if.sv
// Bundle of the custom_axi_ip_mc channel-side signals.
// master: the requester side (drives operands, counts, enables, clear).
// slave : the engine side (drives result, write enables, channel, status, error).
interface custom_axi_ip_mc_if
  import custom_axi_ip_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned CNT_W      = 4
);

  logic [NUM_CH*DATA_WIDTH-1:0] ipreg_data_i;
  logic [NUM_CH*CNT_W-1:0]      ipreg_iter_i;
  logic [NUM_CH-1:0]            enable_i;
  logic                         clear_i;
  logic [DATA_WIDTH-1:0]        ipreg_data_o;
  logic [NUM_CH-1:0]            wen_o;
  logic [$clog2(NUM_CH)-1:0]    ch_o;
  status_e                      status_o;
  logic                         err_o;

  modport master (
    output ipreg_data_i, ipreg_iter_i, enable_i, clear_i,
    input  ipreg_data_o, wen_o, ch_o, status_o, err_o
  );

  modport slave (
    input  ipreg_data_i, ipreg_iter_i, enable_i, clear_i,
    output ipreg_data_o, wen_o, ch_o, status_o, err_o
  );

endinterface

// File: rtl/custom_axi_ip_rr_arb.sv
// Round-robin arbiter: picks the first requesting channel after the last
// accepted one. The pointer only advances when the grant is accepted.
// Ports: clk_i, rst_ni (async, active-low), req_i (per-channel request),
//        accept_i (grant taken this cycle), grant_c (one-hot, combinational),
//        idx_c (granted index, combinational).
module custom_axi_ip_rr_arb #(
  parameter int unsigned NUM_CH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_CH-1:0]         req_i,
  input  logic                      accept_i,
  output logic [NUM_CH-1:0]         grant_c,
  output logic [$clog2(NUM_CH)-1:0] idx_c
);

  localparam int unsigned IDX_W = $clog2(NUM_CH);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             found;
  int unsigned      cand;

  // Search starting one past the pointer, wrapping around all channels.
  always_comb begin
    grant_c = '0;
    idx_c   = '0;
    found   = 1'b0;
    cand    = 0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      cand = (32'(ptr_q) + i) % NUM_CH;
      if (!found && req_i[IDX_W'(cand)]) begin
        found                 = 1'b1;
        idx_c                 = IDX_W'(cand);
        grant_c[IDX_W'(cand)] = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept_i && found) ptr_d = idx_c;
  end

  // Reset to the last channel so channel 0 wins first.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= IDX_W'(NUM_CH - 1);
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/custom_axi_ip_mc.sv
// Multi-channel incrementer: round-robin grants one channel, adds its
// iteration count to its operand one step per cycle, then writes the result
// back with a one-cycle one-hot write enable.
// Ports: clk_i, rst_ni (async, active-low); ipreg_data_i / ipreg_iter_i
//        (packed per-channel operand / count); enable_i (request levels);
//        clear_i (leave ERROR); ipreg_data_o (last result); wen_o (one-hot
//        write enable); ch_o (served channel); status_o (FSM state);
//        err_o (in ERROR).
// Build option: define CUSTOM_AXI_IP_MC_SAT_EN to saturate increments at
// all-ones instead of wrapping.
module custom_axi_ip_mc
  import custom_axi_ip_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned CNT_W      = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ipreg_data_i,
  input  logic [NUM_CH*CNT_W-1:0]      ipreg_iter_i,
  input  logic [NUM_CH-1:0]            enable_i,
  input  logic                         clear_i,
  output logic [DATA_WIDTH-1:0]        ipreg_data_o,
  output logic [NUM_CH-1:0]            wen_o,
  output logic [$clog2(NUM_CH)-1:0]    ch_o,
  output status_e                      status_o,
  output logic                         err_o
);

  localparam int unsigned IDX_W = $clog2(NUM_CH);

  logic [STATE_W-1:0]    state_q, state_d;
  logic [DATA_WIDTH-1:0] value_q, value_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      ch_q, ch_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic [NUM_CH-1:0]     wen_q, wen_d;
  logic                  err_q, err_d;

  logic                  accept_c;
  logic [NUM_CH-1:0]     grant_c;
  logic [IDX_W-1:0]      arb_idx_c;
  logic [DATA_WIDTH-1:0] op_sel_c;
  logic [CNT_W-1:0]      iter_sel_c;
  logic [DATA_WIDTH-1:0] value_inc_c;

  custom_axi_ip_rr_arb #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req_i    (enable_i),
    .accept_i (accept_c),
    .grant_c  (grant_c),
    .idx_c    (arb_idx_c)
  );

  // One-hot AND-OR mux of the granted channel's operand and count.
  always_comb begin
    op_sel_c   = '0;
    iter_sel_c = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (grant_c[c]) begin
        op_sel_c   = op_sel_c   | ipreg_data_i[c*DATA_WIDTH +: DATA_WIDTH];
        iter_sel_c = iter_sel_c | ipreg_iter_i[c*CNT_W +: CNT_W];
      end
    end
  end

`ifdef CUSTOM_AXI_IP_MC_SAT_EN
  assign value_inc_c = (&value_q) ? value_q : value_q + DATA_WIDTH'(1);
`else
  assign value_inc_c = value_q + DATA_WIDTH'(1);
`endif

  // Next-state and output logic.
  always_comb begin
    state_d    = state_q;
    value_d    = value_q;
    cnt_d      = cnt_q;
    ch_d       = ch_q;
    data_out_d = data_out_q;
    wen_d      = '0;
    err_d      = 1'b0;
    accept_c   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|enable_i) begin
          accept_c = 1'b1;
          ch_d     = arb_idx_c;
          if (iter_sel_c == '0) begin
            // Zero-count request is a protocol error: no operation runs.
            state_d = ST_ERROR;
            err_d   = 1'b1;
          end else begin
            value_d = op_sel_c;
            cnt_d   = iter_sel_c;
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        value_d = value_inc_c;
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        data_out_d = value_q;
        wen_d      = NUM_CH'(1) << ch_q;
        state_d    = ST_IDLE;
      end
      ST_ERROR: begin
        if (clear_i) begin
          state_d = ST_IDLE;
        end else begin
          err_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_ERROR;
        err_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      value_q    <= '0;
      cnt_q      <= '0;
      ch_q       <= '0;
      data_out_q <= '0;
      wen_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      value_q    <= value_d;
      cnt_q      <= cnt_d;
      ch_q       <= ch_d;
      data_out_q <= data_out_d;
      wen_q      <= wen_d;
      err_q      <= err_d;
    end
  end

  assign ipreg_data_o = data_out_q;
  assign wen_o        = wen_q;
  assign ch_o         = ch_q;
  assign status_o     = to_status(state_q);
  assign err_o        = err_q;

endmodule

// File: tb/tb_custom_axi_ip_mc.sv
// Directed self-checking bench for custom_axi_ip_mc (default parameters).
module tb_custom_axi_ip_mc;
  import custom_axi_ip_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned NC = 4;
  localparam int unsigned CW = 4;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  logic ok;

  custom_axi_ip_mc_if #(.DATA_WIDTH(DW), .NUM_CH(NC), .CNT_W(CW)) bus ();

  custom_axi_ip_mc #(.DATA_WIDTH(DW), .NUM_CH(NC), .CNT_W(CW)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .ipreg_data_i (bus.ipreg_data_i),
    .ipreg_iter_i (bus.ipreg_iter_i),
    .enable_i     (bus.enable_i),
    .clear_i      (bus.clear_i),
    .ipreg_data_o (bus.ipreg_data_o),
    .wen_o        (bus.wen_o),
    .ch_o         (bus.ch_o),
    .status_o     (bus.status_o),
    .err_o        (bus.err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_ch(input int c, input logic [DW-1:0] d, input logic [CW-1:0] it);
    bus.ipreg_data_i[c*DW +: DW] = d;
    bus.ipreg_iter_i[c*CW +: CW] = it;
  endtask

  // Step until a write enable appears, bounded.
  task automatic wait_wen(input int max_cycles, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      step(1);
      if (bus.wen_o != '0) seen = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] exp_wrap;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b1;
    bus.ipreg_data_i = '0;
    bus.ipreg_iter_i = '0;
    bus.enable_i     = '0;
    bus.clear_i      = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    // Reset state (async)
    check("rst_status", 64'(bus.status_o), 64'd0);
    check("rst_data",   64'(bus.ipreg_data_o), 64'd0);
    check("rst_wen",    64'(bus.wen_o), 64'd0);
    check("rst_ch",     64'(bus.ch_o), 64'd0);
    check("rst_err",    64'(bus.err_o), 64'd0);
    step(2);
    rst_n = 1'b1;
    step(1);

    // Single op: ch0 0x10 + 3
    set_ch(0, 32'h10, 4'd3);
    bus.enable_i = 4'b0001;
    step(1);
    check("s_grant_status", 64'(bus.status_o), 64'd1);
    check("s_grant_ch",     64'(bus.ch_o), 64'd0);
    step(1);
    check("s_busy2_wen", 64'(bus.wen_o), 64'd0);
    step(2);
    check("s_done_status", 64'(bus.status_o), 64'd2);
    check("s_done_wen",    64'(bus.wen_o), 64'd0);
    step(1);
    check("s_wen",    64'(bus.wen_o), 64'b0001);
    check("s_data",   64'(bus.ipreg_data_o), 64'h13);
    check("s_ch",     64'(bus.ch_o), 64'd0);
    check("s_status", 64'(bus.status_o), 64'd0);
    bus.enable_i = '0;
    step(1);
    check("s_wen_once", 64'(bus.wen_o), 64'd0);
    // clear_i outside ERROR is ignored
    bus.clear_i = 1'b1;
    step(1);
    bus.clear_i = 1'b0;
    check("clr_idle_status", 64'(bus.status_o), 64'd0);

    // Round-robin from reset: order 0,1,2,3,0
    do_reset();
    for (int c = 0; c < 4; c++) set_ch(c, 32'(c) * 32'h100, 4'd1);
    bus.enable_i = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      int exp_c;
      exp_c = k % 4;
      wait_wen(10, ok);
      check("rr_seen", 64'(ok), 64'd1);
      check("rr_wen",  64'(bus.wen_o), 64'(4'b0001 << exp_c));
      check("rr_ch",   64'(bus.ch_o), 64'(exp_c));
      check("rr_data", 64'(bus.ipreg_data_o), 64'(32'(exp_c) * 32'h100 + 32'd1));
      if (k == 4) bus.enable_i = '0;
      step(1);
      check("rr_wen_pulse", 64'(bus.wen_o), 64'd0);
    end
    step(4);

    // Wrap / saturate on ch3
`ifdef CUSTOM_AXI_IP_MC_SAT_EN
    exp_wrap = 32'hFFFF_FFFF;
`else
    exp_wrap = 32'h0000_0001;
`endif
    set_ch(3, 32'hFFFF_FFFE, 4'd3);
    bus.enable_i = 4'b1000;
    wait_wen(10, ok);
    bus.enable_i = '0;
    check("wrap_seen", 64'(ok), 64'd1);
    check("wrap_wen",  64'(bus.wen_o), 64'b1000);
    check("wrap_ch",   64'(bus.ch_o), 64'd3);
    check("wrap_data", 64'(bus.ipreg_data_o), 64'(exp_wrap));
    step(2);

    // Error on zero count (ch2)
    set_ch(2, 32'h55, 4'd0);
    bus.enable_i = 4'b0100;
    step(1);
    check("err_status", 64'(bus.status_o), 64'd3);
    check("err_err",    64'(bus.err_o), 64'd1);
    check("err_ch",     64'(bus.ch_o), 64'd2);
    check("err_wen",    64'(bus.wen_o), 64'd0);
    bus.enable_i = 4'b0001;
    step(3);
    check("err_hold_status", 64'(bus.status_o), 64'd3);
    check("err_hold_wen",    64'(bus.wen_o), 64'd0);
    check("err_hold_ch",     64'(bus.ch_o), 64'd2);
    bus.enable_i = '0;
    bus.clear_i  = 1'b1;
    step(1);
    bus.clear_i  = 1'b0;
    check("clr_status", 64'(bus.status_o), 64'd0);
    check("clr_err",    64'(bus.err_o), 64'd0);
    step(1);

    // Reset mid-BUSY on ch1
    set_ch(1, 32'h20, 4'd8);
    bus.enable_i = 4'b0010;
    step(1);
    check("mb_grant_status", 64'(bus.status_o), 64'd1);
    check("mb_grant_ch",     64'(bus.ch_o), 64'd1);
    step(3);
    check("mb_busy4_status", 64'(bus.status_o), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mb_status", 64'(bus.status_o), 64'd0);
    check("mb_data",   64'(bus.ipreg_data_o), 64'd0);
    check("mb_wen",    64'(bus.wen_o), 64'd0);
    check("mb_ch",     64'(bus.ch_o), 64'd0);
    check("mb_err",    64'(bus.err_o), 64'd0);
    step(2);
    check("mb_hold_wen", 64'(bus.wen_o), 64'd0);
    set_ch(0, 32'h7, 4'd2);
    bus.enable_i = 4'b0011;
    rst_n = 1'b1;
    step(1);
    check("mb_regrant_status", 64'(bus.status_o), 64'd1);
    check("mb_regrant_ch",     64'(bus.ch_o), 64'd0);
    wait_wen(10, ok);
    check("mb_regrant_seen", 64'(ok), 64'd1);
    check("mb_regrant_wen",  64'(bus.wen_o), 64'b0001);
    check("mb_regrant_data", 64'(bus.ipreg_data_o), 64'h9);
    bus.enable_i = '0;
    step(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
